// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit.
// Access size is taken from funct3[1:0]: 00 byte, 01 half, 1x word (reserved codes fall into word).
package mem_access_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   function automatic logic is_byte(input logic [2:0] f3);
      return f3[1:0] == 2'b00;
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return f3[1:0] == 2'b01;
   endfunction

   // Drop the address bits that lie inside the access size.
   function automatic logic [1:0] mask_lo(input logic [2:0] f3, input logic [1:0] a);
      if (is_byte(f3)) return a;
      else if (is_half(f3)) return {a[1], 1'b0};
      else return 2'b00;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      if (is_byte(f3)) return 1'b0;
      else if (is_half(f3)) return a[0];
      else return a != 2'b00;
   endfunction

   function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] a);
      if (is_byte(f3)) return 4'b0001 << a;
      else if (is_half(f3)) return a[1] ? 4'b1100 : 4'b0011;
      else return 4'b1111;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (is_byte(f3)) return {4{d[7:0]}};
      else if (is_half(f3)) return {2{d[15:0]}};
      else return d;
   endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
// Purely combinational; reserved funct3 codes pass the word through.
module load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  a,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      case (a)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = a[1] ? word[31:16] : word[15:0];
      case (funct3)
         FUNCT3_B:  data = {{24{b[7]}}, b};
         FUNCT3_BU: data = {24'h0, b};
         FUNCT3_H:  data = {{16{h[15]}}, h};
         FUNCT3_HU: data = {16'h0, h};
         default:   data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one access per instruction over a valid/ready data bus.
// Latency: min 3 stall cycles (IDLE, REQ, WAIT_RSP) then one DONE cycle; waits indefinitely on dreq_ready/drsp_valid.
// Backpressure: request payload held stable until accepted; MEM_MISALIGN_TRAP_EN adds misalign_fault and traps misaligned H/W.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [31:0]       WriteDataM,
   input  logic [2:0]        Funct3M,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   output logic              StallM,
   output logic [31:0]       ReadDataM,
   output logic              dreq_valid,
   input  logic              dreq_ready,
   output logic [ADDR_W-1:0] dreq_addr,
   output logic              dreq_we,
   output logic [31:0]       dreq_wdata,
   output logic [3:0]        dreq_wstrb,
   input  logic              drsp_valid,
   input  logic [31:0]       drsp_rdata
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_fault
`endif
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("mem_access_unit: DATA_W must be 32");
   end

   state_t      state;
   logic [1:0]  a_lo_q;
   logic [2:0]  f3_q;
   logic [1:0]  a_lo;
   logic [31:0] load_data;
   logic        access;

   assign access = MemReadM | MemWriteM;
   assign a_lo   = mask_lo(Funct3M, ALUResultM[1:0]);
   assign StallM = (state == IDLE && access) || state == REQ || state == WAIT_RSP;

   load_align u_load_align (
      .word   (drsp_rdata),
      .a      (a_lo_q),
      .funct3 (f3_q),
      .data   (load_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ReadDataM  <= '0;
         dreq_valid <= 1'b0;
         dreq_addr  <= '0;
         dreq_we    <= 1'b0;
         dreq_wdata <= '0;
         dreq_wstrb <= '0;
         a_lo_q     <= '0;
         f3_q       <= FUNCT3_W;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_fault <= 1'b0;
`endif
      end else begin
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_fault <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (access) begin
`ifdef MEM_MISALIGN_TRAP_EN
                  if (misaligned(Funct3M, ALUResultM[1:0])) begin
                     state          <= DONE;
                     ReadDataM      <= '0;
                     misalign_fault <= 1'b1;
                  end else
`endif
                  begin
                     // A simultaneous read and write is issued as a store.
                     state      <= REQ;
                     dreq_valid <= 1'b1;
                     dreq_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
                     dreq_we    <= MemWriteM;
                     dreq_wdata <= store_wdata(Funct3M, WriteDataM);
                     dreq_wstrb <= MemWriteM ? store_wstrb(Funct3M, a_lo) : 4'b0000;
                     a_lo_q     <= a_lo;
                     f3_q       <= Funct3M;
                  end
               end
            end
            REQ: begin
               if (dreq_ready) begin
                  dreq_valid <= 1'b0;
                  state      <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (drsp_valid) begin
                  ReadDataM <= load_data;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: bus-side request and load-result expectations are queued
// when an access is driven and compared as the DUT presents them.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] ALUResultM = '0;
   logic [31:0] WriteDataM = '0;
   logic [2:0]  Funct3M = '0;
   logic        MemReadM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic        StallM;
   logic [31:0] ReadDataM;
   logic        dreq_valid;
   logic        dreq_ready = 1'b0;
   logic [31:0] dreq_addr;
   logic        dreq_we;
   logic [31:0] dreq_wdata;
   logic [3:0]  dreq_wstrb;
   logic        drsp_valid = 1'b0;
   logic [31:0] drsp_rdata = '0;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_fault;
`endif

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .Funct3M    (Funct3M),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .StallM     (StallM),
      .ReadDataM  (ReadDataM),
      .dreq_valid (dreq_valid),
      .dreq_ready (dreq_ready),
      .dreq_addr  (dreq_addr),
      .dreq_we    (dreq_we),
      .dreq_wdata (dreq_wdata),
      .dreq_wstrb (dreq_wstrb),
      .drsp_valid (drsp_valid),
      .drsp_rdata (drsp_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign_fault (misalign_fault)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } req_t;

   req_t        req_q[$];
   logic [31:0] rd_q[$];
   int          total = 0;
   int          bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Reference behaviour, written from the ISA view of each access.
   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
      logic [31:0] s;
      case (f3)
         3'b000: begin s = w >> (8 * a); return {{24{s[7]}}, s[7:0]}; end
         3'b100: begin s = w >> (8 * a); return {24'h0, s[7:0]}; end
         3'b001: begin s = a[1] ? (w >> 16) : w; return {{16{s[15]}}, s[15:0]}; end
         3'b101: begin s = a[1] ? (w >> 16) : w; return {16'h0, s[15:0]}; end
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
         2'b01:   return {d[15:0], d[15:0]};
         default: return d;
      endcase
   endfunction

   // Drives one access and plays the memory side until the DONE cycle.
   task automatic run_access(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                             input logic rd, input logic wr, input logic [31:0] rword,
                             input int delay, input int exp_stall, input logic chk_rd,
                             input logic exp_fault);
      int   stalls = 0;
      int   wait_rdy = delay;
      bit   rsp_pending = 0;
      bit   done = 0;
      bit   have_req = 0;
      req_t cur;
      logic [31:0] exp_rd;
      @(posedge clk);
      #1;
      ALUResultM = addr; WriteDataM = wd; Funct3M = f3; MemReadM = rd; MemWriteM = wr;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (dreq_valid) begin
            if (!have_req) begin
               if (req_q.size() == 0) check("spurious_req", {31'b0, dreq_valid}, 32'd0);
               else begin cur = req_q.pop_front(); have_req = 1; end
            end
            if (have_req) begin
               check("req_addr", dreq_addr, cur.addr);
               check("req_we", {31'b0, dreq_we}, {31'b0, cur.we});
               check("req_wstrb", {28'b0, dreq_wstrb}, {28'b0, cur.strb});
               if (cur.we) check("req_wdata", dreq_wdata, cur.wdata);
            end
         end
         if (StallM) stalls++;
         else begin
            done = 1;
            check("stall_cycles", stalls, exp_stall);
            if (chk_rd) begin
               exp_rd = rd_q.pop_front();
               check("read_data", ReadDataM, exp_rd);
            end
`ifdef MEM_MISALIGN_TRAP_EN
            check("fault", {31'b0, misalign_fault}, {31'b0, exp_fault});
`endif
            MemReadM = 0; MemWriteM = 0;
         end
         drsp_valid = 0;
         if (rsp_pending) begin drsp_valid = 1; drsp_rdata = rword; rsp_pending = 0; end
         dreq_ready = 0;
         if (dreq_valid) begin
            if (wait_rdy == 0) begin dreq_ready = 1; rsp_pending = 1; end
            else wait_rdy--;
         end
      end
      if (!done) begin
         check("timeout", {31'b0, done}, 32'd1);
         MemReadM = 0; MemWriteM = 0; dreq_ready = 0; drsp_valid = 0;
      end
      if (!exp_fault && !have_req) check("missing_req", {31'b0, have_req}, 32'd1);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rword, input int delay);
      req_t r;
      r.addr = {addr[31:2], 2'b00}; r.we = 1'b0; r.strb = 4'b0000; r.wdata = '0;
      req_q.push_back(r);
      rd_q.push_back(m_load(rword, addr[1:0], f3));
      run_access(addr, 32'h0, f3, 1'b1, 1'b0, rword, delay, 3 + delay, 1'b1, 1'b0);
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd, input int delay);
      req_t r;
      r.addr = {addr[31:2], 2'b00}; r.we = 1'b1; r.strb = m_strb(f3, addr[1:0]); r.wdata = m_wdata(f3, wd);
      req_q.push_back(r);
      run_access(addr, wd, f3, 1'b0, 1'b1, 32'h0, delay, 3 + delay, 1'b0, 1'b0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] addr;
      #12;
      check("rst_stall", {31'b0, StallM}, 32'd0);
      check("rst_rdata", ReadDataM, 32'd0);
      check("rst_valid", {31'b0, dreq_valid}, 32'd0);
      check("rst_addr", dreq_addr, 32'd0);
      check("rst_we", {31'b0, dreq_we}, 32'd0);
      check("rst_wdata", dreq_wdata, 32'd0);
      check("rst_wstrb", {28'b0, dreq_wstrb}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
      check("rst_fault", {31'b0, misalign_fault}, 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;

      do_load(32'h100, 3'b010, 32'hDEADBEEF, 0);
      do_load(32'h103, 3'b000, 32'h80FF0000, 0);
      do_load(32'h103, 3'b100, 32'h80FF0000, 0);
      do_store(32'h102, 3'b001, 32'h1234ABCD, 0);
      do_store(32'h200, 3'b010, 32'h11223344, 5);
      do_load(32'h102, 3'b001, 32'h80017FFF, 1);
      do_load(32'h100, 3'b101, 32'h8001F00F, 0);
      do_store(32'h101, 3'b000, 32'h000000A5, 2);
      do_load(32'h104, 3'b011, 32'hA5A55A5A, 0);

      for (int i = 0; i < 16; i++) begin
         addr = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000;
               1: f3 = 3'b001;
               2: f3 = 3'b010;
               3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
            if (f3[1:0] == 2'b01) addr[0] = 1'b0;
            if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            do_load(addr, f3, $urandom, $urandom_range(0, 2));
         end else begin
            f3 = 3'($urandom_range(0, 2));
            if (f3[1:0] == 2'b01) addr[0] = 1'b0;
            if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            do_store(addr, f3, $urandom, $urandom_range(0, 2));
         end
      end

`ifdef MEM_MISALIGN_TRAP_EN
      rd_q.push_back(32'h0);
      run_access(32'h101, 32'h0, 3'b010, 1'b1, 1'b0, 32'h13572468, 0, 1, 1'b1, 1'b1);
      do_load(32'h100, 3'b010, 32'h24681357, 0);
`else
      do_load(32'h101, 3'b010, 32'h13572468, 0);
`endif

      // Reset while waiting for the response; the late response must be dropped.
      @(posedge clk);
      #1;
      ALUResultM = 32'h300; Funct3M = 3'b010; MemReadM = 1'b1; MemWriteM = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_req", {31'b0, dreq_valid}, 32'd1);
      dreq_ready = 1'b1;
      @(negedge clk);
      dreq_ready = 1'b0;
      check("rst_mid_wait", {31'b0, StallM}, 32'd1);
      reset_n = 1'b0;
      MemReadM = 1'b0;
      #2;
      check("rst_async_stall", {31'b0, StallM}, 32'd0);
      check("rst_async_rdata", ReadDataM, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      drsp_valid = 1'b1; drsp_rdata = 32'hCAFEF00D;
      @(negedge clk);
      drsp_valid = 1'b0;
      check("late_rsp_stall", {31'b0, StallM}, 32'd0);
      check("late_rsp_rdata", ReadDataM, 32'd0);
      check("late_rsp_valid", {31'b0, dreq_valid}, 32'd0);
      @(negedge clk);
      check("late_rsp_rdata2", ReadDataM, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
